// File: rtl/mem_tag_responder.sv
// mem_tag_responder: tagged D$/I$ request arbiter, SRAM driver and fixed-latency response pipeline.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating D$/I$ grants; otherwise D$ has fixed priority.
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif
`ifndef MEM_BLOCK_BITS
`define MEM_BLOCK_BITS 64
`endif
module mem_tag_responder #(
  parameter int NUM_TAGS    = `NUM_MEM_TAGS + 1,
  parameter int MEM_LATENCY = 4,
  parameter int SRAM_AW     = 13,
  localparam int TW = $clog2(NUM_TAGS),
  localparam int BW = `MEM_BLOCK_BITS
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               dc_req_valid_i,
  input  logic               dc_req_store_i,
  input  logic [31:0]        dc_req_addr_i,
  input  logic [BW-1:0]      dc_req_wdata_i,
  output logic               dc_req_accepted_o,
  input  logic               ic_req_valid_i,
  input  logic [31:0]        ic_req_addr_i,
  output logic               ic_req_accepted_o,
  output logic [TW-1:0]      current_req_tag_o,
  output logic [BW-1:0]      mem_data_o,
  output logic [TW-1:0]      mem_data_tag_o,
  output logic               sram_re_o,
  output logic               sram_we_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [BW-1:0]      sram_wdata_o,
  input  logic [BW-1:0]      sram_rdata_i
);
  logic [NUM_TAGS-1:1] free_q, free_d;
  logic [TW-1:0]       tag_q [MEM_LATENCY];
  logic [BW-1:0]       data_q [1:MEM_LATENCY-1];
  logic [TW-1:0]       alloc_tag;
  logic                tag_avail, dc_ok, ic_ok, load_acc, store_acc, unused_addr;
  logic [31:0]         req_addr;
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 1; i--) alloc_tag = free_q[i] ? TW'(i) : alloc_tag;
  end
  assign tag_avail = |free_q;
  assign dc_ok     = dc_req_valid_i && (dc_req_store_i || tag_avail);
  assign ic_ok     = ic_req_valid_i && tag_avail;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_dc_q = 1 when D$ took the most recent grant; a tag-starved port never gets a grant, so keeps its turn
  logic last_dc_q, last_dc_d;
  assign dc_req_accepted_o = dc_ok && !(ic_ok && last_dc_q);
  assign last_dc_d = (dc_req_accepted_o || ic_req_accepted_o) ? dc_req_accepted_o : last_dc_q;
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) last_dc_q <= 1'b0;
    else last_dc_q <= last_dc_d;
`else
  assign dc_req_accepted_o = dc_ok;
`endif
  assign ic_req_accepted_o = ic_ok && !dc_req_accepted_o;
  assign store_acc         = dc_req_accepted_o && dc_req_store_i;
  assign load_acc          = (dc_req_accepted_o && !dc_req_store_i) || ic_req_accepted_o;
  assign req_addr          = dc_req_accepted_o ? dc_req_addr_i : ic_req_addr_i;
  assign unused_addr       = ^{req_addr[31:SRAM_AW+3], req_addr[2:0]};
  assign current_req_tag_o = load_acc ? alloc_tag : '0;
  assign sram_re_o         = load_acc;
  assign sram_we_o         = store_acc;
  assign sram_addr_o       = (load_acc || store_acc) ? req_addr[SRAM_AW+2:3] : '0;
  assign sram_wdata_o      = store_acc ? dc_req_wdata_i : '0;
  assign mem_data_o        = data_q[MEM_LATENCY-1];
  assign mem_data_tag_o    = tag_q[MEM_LATENCY-1];
  // Allocation only looks at free_q, so a tag freed by this cycle's broadcast is reissued next cycle at the earliest
  always_comb begin
    free_d = free_q;
    if (tag_q[MEM_LATENCY-1] != '0) free_d[tag_q[MEM_LATENCY-1]] = 1'b1;
    if (load_acc) free_d[alloc_tag] = 1'b0;
  end
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      free_q <= '1;
      for (int i = 0; i < MEM_LATENCY; i++) tag_q[i] <= '0;
      for (int i = 1; i < MEM_LATENCY; i++) data_q[i] <= '0;
    end else begin
      free_q   <= free_d;
      tag_q[0] <= current_req_tag_o;
      for (int i = 1; i < MEM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      data_q[1] <= (tag_q[0] != '0) ? sram_rdata_i : '0;
      for (int i = 2; i < MEM_LATENCY; i++) data_q[i] <= data_q[i-1];
    end
endmodule

// File: tb/tb_mem_tag_responder.sv
// tb_mem_tag_responder: directed bench for mem_tag_responder with a small tag pool (tags 1..3).
`ifndef MEM_BLOCK_BITS
`define MEM_BLOCK_BITS 64
`endif
module tb_mem_tag_responder;
  localparam int NT = 4, TW = 2, BW = `MEM_BLOCK_BITS, AW = 13;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, dc_valid, dc_store, dc_acc, ic_valid, ic_acc, sram_re, sram_we;
  logic [31:0] dc_addr, ic_addr;
  logic [BW-1:0] dc_wdata, mem_data, sram_wdata, sram_rdata;
  logic [TW-1:0] cur_tag, mem_tag;
  logic [AW-1:0] sram_addr;
  logic pre_we = 1'b0;
  logic [AW-1:0] pre_addr;
  logic [BW-1:0] pre_data;
  logic [BW-1:0] mem [8192];
  int errors = 0, checks = 0;

  mem_tag_responder #(.NUM_TAGS(NT), .MEM_LATENCY(4), .SRAM_AW(AW)) dut (
    .clock_i(clk), .reset_ni(reset_n),
    .dc_req_valid_i(dc_valid), .dc_req_store_i(dc_store), .dc_req_addr_i(dc_addr),
    .dc_req_wdata_i(dc_wdata), .dc_req_accepted_o(dc_acc),
    .ic_req_valid_i(ic_valid), .ic_req_addr_i(ic_addr), .ic_req_accepted_o(ic_acc),
    .current_req_tag_o(cur_tag), .mem_data_o(mem_data), .mem_data_tag_o(mem_tag),
    .sram_re_o(sram_re), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic dv, input logic ds, input logic [31:0] da, input logic [BW-1:0] dw,
                       input logic iv, input logic [31:0] ia);
    dc_valid = dv; dc_store = ds; dc_addr = da; dc_wdata = dw; ic_valid = iv; ic_addr = ia;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [BW-1:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1 pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    preload(13'h20, 64'hDEAD);
    preload(13'h40, 64'h1111);
    preload(13'h41, 64'h2222);
    preload(13'h42, 64'h3333);
    preload(13'h60, 64'hBEEF);
    @(negedge clk); #1;
    checks++; if (mem_tag !== '0) begin errors++; $display("FAIL reset_tag: got %0h expected 0", mem_tag); end
    checks++; if (mem_data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", mem_data); end
    checks++; if ({dc_acc, ic_acc, sram_re, sram_we} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {dc_acc, ic_acc, sram_re, sram_we}); end
    checks++; if (cur_tag !== '0) begin errors++; $display("FAIL reset_cur_tag: got %0h expected 0", cur_tag); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_single_load();
    @(negedge clk) drive(0, 0, 0, 0, 1, 32'h100); #1;
    checks++; if ({dc_acc, ic_acc} !== 2'b01) begin errors++; $display("FAIL t1_accept: got %b expected 01", {dc_acc, ic_acc}); end
    checks++; if (cur_tag !== 2'd1) begin errors++; $display("FAIL t1_tag: got %0d expected 1", cur_tag); end
    checks++; if (sram_re !== 1'b1 || sram_addr !== 13'h20) begin errors++; $display("FAIL t1_sram: got re=%b addr=%0h expected re=1 addr=20", sram_re, sram_addr); end
    @(negedge clk) drive(0, 0, 0, 0, 0, 0); #1;
    checks++; if (mem_tag !== '0) begin errors++; $display("FAIL t1_early_resp: got %0d expected 0", mem_tag); end
    repeat (3) @(negedge clk); #1;
    checks++; if (mem_tag !== 2'd1) begin errors++; $display("FAIL t1_resp_tag: got %0d expected 1", mem_tag); end
    checks++; if (mem_data !== 64'hDEAD) begin errors++; $display("FAIL t1_resp_data: got %0h expected dead", mem_data); end
  endtask

  task automatic test_store_then_load();
    @(negedge clk) drive(1, 1, 32'h40, 64'h55, 0, 0); #1;
    checks++; if ({dc_acc, ic_acc, sram_we, sram_re} !== 4'b1010) begin errors++; $display("FAIL t2_store_accept: got %b expected 1010", {dc_acc, ic_acc, sram_we, sram_re}); end
    checks++; if (cur_tag !== '0) begin errors++; $display("FAIL t2_store_tag: got %0d expected 0", cur_tag); end
    checks++; if (sram_wdata !== 64'h55 || sram_addr !== 13'h8) begin errors++; $display("FAIL t2_store_sram: got wdata=%0h addr=%0h expected 55/8", sram_wdata, sram_addr); end
    @(negedge clk) drive(0, 0, 0, 0, 1, 32'h40); #1;
    checks++; if (ic_acc !== 1'b1 || cur_tag !== 2'd1) begin errors++; $display("FAIL t2_load: got acc=%b tag=%0d expected 1/1", ic_acc, cur_tag); end
    @(negedge clk) drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk); #1;
    checks++; if (mem_tag !== '0) begin errors++; $display("FAIL t2_store_no_resp: got %0d expected 0", mem_tag); end
    @(negedge clk); #1;
    checks++; if (mem_tag !== 2'd1 || mem_data !== 64'h55) begin errors++; $display("FAIL t2_resp: got tag=%0d data=%0h expected 1/55", mem_tag, mem_data); end
  endtask

  task automatic test_arbitration();
    logic exp_dc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) drive(1, 0, 32'h400, 0, 1, 32'h500); #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_dc = (k % 2 == 0);
`else
      exp_dc = 1'b1;
`endif
      checks++; if ({dc_acc, ic_acc} !== {exp_dc, ~exp_dc}) begin errors++; $display("FAIL t3_grant%0d: got %b expected %b", k, {dc_acc, ic_acc}, {exp_dc, ~exp_dc}); end
      checks++; if (cur_tag !== TW'(k + 1)) begin errors++; $display("FAIL t3_tag%0d: got %0d expected %0d", k, cur_tag, k + 1); end
    end
    @(negedge clk) drive(0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_pool_exhaust();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) drive(0, 0, 0, 0, 1, 32'h200 + 32'(k * 8)); #1;
      checks++; if (ic_acc !== 1'b1 || cur_tag !== TW'(k + 1)) begin errors++; $display("FAIL t4_fill%0d: got acc=%b tag=%0d expected 1/%0d", k, ic_acc, cur_tag, k + 1); end
    end
    @(negedge clk) drive(0, 0, 0, 0, 1, 32'h218); #1;
    checks++; if ({ic_acc, sram_re, cur_tag} !== 4'b0) begin errors++; $display("FAIL t4_empty_refuse: got acc=%b re=%b tag=%0d expected 0/0/0", ic_acc, sram_re, cur_tag); end
    @(negedge clk) drive(1, 1, 32'h800, 64'h77, 1, 32'h218); #1;
    checks++; if ({dc_acc, ic_acc, sram_we} !== 3'b101 || cur_tag !== '0) begin errors++; $display("FAIL t4_store_when_empty: got %b tag=%0d expected 101 tag=0", {dc_acc, ic_acc, sram_we}, cur_tag); end
    checks++; if (mem_tag !== 2'd1 || mem_data !== 64'h1111) begin errors++; $display("FAIL t4_resp1: got tag=%0d data=%0h expected 1/1111", mem_tag, mem_data); end
    @(negedge clk) drive(0, 0, 0, 0, 1, 32'h218); #1;
    checks++; if (ic_acc !== 1'b1 || cur_tag !== 2'd1) begin errors++; $display("FAIL t4_reissue: got acc=%b tag=%0d expected 1/1", ic_acc, cur_tag); end
    checks++; if (mem_tag !== 2'd2 || mem_data !== 64'h2222) begin errors++; $display("FAIL t4_resp2: got tag=%0d data=%0h expected 2/2222", mem_tag, mem_data); end
    @(negedge clk) drive(0, 0, 0, 0, 0, 0); #1;
    checks++; if (mem_tag !== 2'd3 || mem_data !== 64'h3333) begin errors++; $display("FAIL t4_resp3: got tag=%0d data=%0h expected 3/3333", mem_tag, mem_data); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) drive(0, 0, 0, 0, 1, 32'h600 + 32'(k * 8)); #1;
      checks++; if (cur_tag !== TW'(k + 1)) begin errors++; $display("FAIL t5_load%0d: got %0d expected %0d", k, cur_tag, k + 1); end
    end
    @(negedge clk) begin drive(0, 0, 0, 0, 0, 0); reset_n = 1'b0; end
    #1;
    checks++; if (mem_tag !== '0 || mem_data !== '0) begin errors++; $display("FAIL t5_in_reset: got tag=%0d data=%0h expected 0/0", mem_tag, mem_data); end
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (mem_tag !== '0) begin errors++; $display("FAIL t5_dropped%0d: got %0d expected 0", k, mem_tag); end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 1, 32'h100); #1;
    checks++; if (ic_acc !== 1'b1 || cur_tag !== 2'd1) begin errors++; $display("FAIL t5_after_reset: got acc=%b tag=%0d expected 1/1", ic_acc, cur_tag); end
    @(negedge clk) drive(0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_unaligned();
    @(negedge clk) drive(0, 0, 0, 0, 1, 32'h305); #1;
    checks++; if (sram_addr !== 13'h60 || cur_tag !== 2'd1) begin errors++; $display("FAIL t6_unaligned: got addr=%0h tag=%0d expected 60/1", sram_addr, cur_tag); end
    @(negedge clk) drive(0, 0, 0, 0, 1, 32'h300); #1;
    checks++; if (sram_addr !== 13'h60 || cur_tag !== 2'd2) begin errors++; $display("FAIL t6_aligned: got addr=%0h tag=%0d expected 60/2", sram_addr, cur_tag); end
    @(negedge clk) drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk); #1;
    checks++; if (mem_tag !== 2'd1 || mem_data !== 64'hBEEF) begin errors++; $display("FAIL t6_resp_unaligned: got tag=%0d data=%0h expected 1/beef", mem_tag, mem_data); end
    @(negedge clk); #1;
    checks++; if (mem_tag !== 2'd2 || mem_data !== 64'hBEEF) begin errors++; $display("FAIL t6_resp_aligned: got tag=%0d data=%0h expected 2/beef", mem_tag, mem_data); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_then_load();
    test_arbitration();
    test_pool_exhaust();
    test_reset_mid();
    test_unaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
